balance_bcd_reader: RTL

// - Reader side of the bank balance register: samples the 27-bit binary balance and converts it
//   to packed BCD digits for the seven-segment display driver.
// - Iterative shift-add-3 (double dabble) conversion, one balance bit per clock.
// - Triggered by an explicit request or by an internal refresh timer.
// - Display consumes only a committed, coherent digit set; it never sees a partial conversion.

---
 rtl/balance_bcd_reader_pkg.sv | 10 +
 rtl/balance_bcd_reader_if.sv | 12 +
 rtl/balance_bcd_reader_bcd_add3.sv | 9 +
 rtl/balance_bcd_reader.sv | 102 ++++++++++
 4 files changed

// File: rtl/balance_bcd_reader_pkg.sv
// balance_bcd_reader_pkg: shared widths, saturation limit and FSM encoding for the balance reader
package balance_bcd_reader_pkg;
    localparam int BAL_W = 27;
    localparam int NDIG  = 8;
    localparam int DIG_W = 4 * NDIG;
    localparam int CNT_W = $clog2(BAL_W + 1);
    localparam logic [BAL_W-1:0] MAX_BAL = BAL_W'(10 ** NDIG - 1);
    typedef logic [3:0] bcd_digit_t;
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} state_e;
endpackage

// File: rtl/balance_bcd_reader_if.sv
// balance_bcd_reader_if: balance/request inputs and committed BCD display outputs
interface balance_bcd_reader_if;
    import balance_bcd_reader_pkg::*;
    logic [BAL_W-1:0] balance;
    logic             req;
    logic [DIG_W-1:0] digits;
    logic             ovf;
    logic             busy;
    logic             done;
    modport master (output balance, req, input digits, ovf, busy, done);
    modport slave  (input balance, req, output digits, ovf, busy, done);
endinterface

// File: rtl/balance_bcd_reader_bcd_add3.sv
// bcd_add3: double-dabble digit correction, adds 3 to any digit of 5 or more
module bcd_add3
    import balance_bcd_reader_pkg::*;
(
    input  bcd_digit_t d_i,
    output bcd_digit_t d_o
);
    assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;
endmodule

// File: rtl/balance_bcd_reader.sv
// balance_bcd_reader: samples the binary balance and converts it to committed packed BCD digits
module balance_bcd_reader
    import balance_bcd_reader_pkg::*;
#(
    parameter int REFRESH_CYCLES = 100000
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    balance_bcd_reader_if.slave  bus
);
    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [RW-1:0] REF_LAST = (REFRESH_CYCLES > 0) ? RW'(REFRESH_CYCLES - 1) : '0;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BAL_W-1:0] sat_q, sat_d;
    logic [DIG_W-1:0] bcd_q, bcd_d, bcd_adj;
    logic [DIG_W-1:0] digits_q, digits_d;
    logic [RW-1:0]    ref_q, ref_d;
    logic             ovf_q, ovf_d, ovf_nx_q, ovf_nx_d;
    logic             done_q, done_d, pend_q, pend_d;
    logic             tick, over;

    genvar g;
    generate
        for (g = 0; g < NDIG; g++) begin : g_add3
            bcd_add3 u_add3 (.d_i(bcd_q[4*g +: 4]), .d_o(bcd_adj[4*g +: 4]));
        end
    endgenerate

    // Next-state logic: FSM, shift-add-3 datapath, pending merge and free-running refresh timer
    always_comb begin
        tick     = (REFRESH_CYCLES > 0) && (ref_q == REF_LAST);
        ref_d    = (tick || REFRESH_CYCLES == 0) ? '0 : ref_q + 1'b1;
        over     = bus.balance > MAX_BAL;
        pend_d   = (state_q == IDLE) ? 1'b0 : (pend_q | bus.req | tick);
        state_d  = state_q;
        cnt_d    = cnt_q;
        sat_d    = sat_q;
        bcd_d    = bcd_q;
        digits_d = digits_q;
        ovf_d    = ovf_q;
        ovf_nx_d = ovf_nx_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE:    state_d = (bus.req | pend_q | tick) ? LOAD : IDLE;
            LOAD: begin
                sat_d    = over ? MAX_BAL : bus.balance;
                ovf_nx_d = over;
                bcd_d    = '0;
                cnt_d    = CNT_W'(BAL_W);
                state_d  = SHIFT;
            end
            SHIFT: begin
                bcd_d   = {bcd_adj[DIG_W-2:0], sat_q[BAL_W-1]};
                sat_d   = {sat_q[BAL_W-2:0], 1'b0};
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_q == CNT_W'(1)) ? COMMIT : SHIFT;
            end
            COMMIT: begin
                digits_d = bcd_q;
                ovf_d    = ovf_nx_q;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any conversion and clears the display
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sat_q    <= '0;
            bcd_q    <= '0;
            digits_q <= '0;
            ref_q    <= '0;
            ovf_q    <= 1'b0;
            ovf_nx_q <= 1'b0;
            done_q   <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sat_q    <= sat_d;
            bcd_q    <= bcd_d;
            digits_q <= digits_d;
            ref_q    <= ref_d;
            ovf_q    <= ovf_d;
            ovf_nx_q <= ovf_nx_d;
            done_q   <= done_d;
            pend_q   <= pend_d;
        end
    end

    assign bus.digits = digits_q;
    assign bus.ovf    = ovf_q;
    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = done_q;
endmodule
